// File: rtl/apb2axi_bridge_single_if.sv
// Bus bundle for apb2axi_bridge_single: APB slave side plus single-beat AXI master side.
// modport slave is the bridge's view; modport master is the surrounding system's view.
interface apb2axi_bridge_single_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  // APB
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  // AXI write address / data / response
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst, awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid, awready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid, wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  // AXI read address / data
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst, arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/apb2axi_bridge_single.sv
// APB slave to AXI master bridge: one APB transfer becomes one single-beat 32-bit AXI
// read or write, with the APB access phase held until the AXI response returns.
module apb2axi_bridge_single #(
  parameter int unsigned     ADDR_W = 32,
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  apb2axi_bridge_single_if.slave bus
);

  typedef enum logic [2:0] {IDLE, W_REQ, W_RESP, R_REQ, R_RESP, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, prdata_q;
  logic [3:0]        strb_q;
  logic [2:0]        prot_q;
  logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic              pready_q, pslverr_q;
  logic              aw_done, w_done;
  logic              unused_ids;

  // A channel counts as done once its valid has dropped or is being accepted this cycle.
  assign aw_done    = ~awvalid_q | bus.awready;
  assign w_done     = ~wvalid_q | bus.wready;
  assign unused_ids = ^{bus.bid, bus.rid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      prdata_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            addr_q  <= {bus.paddr[ADDR_W-1:2], 2'b00};
            wdata_q <= bus.pwdata;
            strb_q  <= (bus.pstrb == '0) ? '1 : bus.pstrb;
            prot_q  <= bus.pprot;
            if (bus.pwrite) begin
              state_q   <= W_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= R_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        W_REQ: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q  <= W_RESP;
            bready_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            bready_q  <= 1'b0;
            pslverr_q <= bus.bresp[1];
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        R_REQ: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.rvalid) begin
            rready_q  <= 1'b0;
            prdata_q  <= bus.rdata;
            pslverr_q <= bus.rresp[1] | ~bus.rlast;
            pready_q  <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = prot_q;
  assign bus.awvalid = awvalid_q;

  assign bus.wid     = AXI_ID;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = strb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid_q;

  assign bus.bready  = bready_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = prot_q;
  assign bus.arvalid = arvalid_q;

  assign bus.rready  = rready_q;

endmodule

// File: tb/tb_apb2axi_bridge_single.sv
// Bench for apb2axi_bridge_single: vector table of APB transfers against a stall-configurable
// AXI slave, expected APB results queued at setup and checked when pready appears.
module tb_apb2axi_bridge_single;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned MAXCYC = 60;
  localparam int unsigned NVEC   = 12;

  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int unsigned aw_st, w_st, ar_st, b_st, r_st;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        rlast;
    bit          b2b;
    int unsigned exp_cyc;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    int unsigned cyc;
    logic        err;
    logic [31:0] prdata;
  } exp_t;

  logic        clk, rst_n;
  int unsigned n_cmp, n_bad;
  logic [31:0] last_rd;
  exp_t        sbq[$];
  vec_t        tbl[NVEC];

  apb2axi_bridge_single_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  apb2axi_bridge_single #(.ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(4'hA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot,
                              input int unsigned aw, input int unsigned w, input int unsigned ar,
                              input int unsigned b, input int unsigned r, input logic [1:0] resp,
                              input logic [31:0] rdata, input logic rlast, input bit b2b,
                              input int unsigned cyc, input logic err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.aw_st = aw; v.w_st = w; v.ar_st = ar; v.b_st = b; v.r_st = r;
    v.resp = resp; v.rdata = rdata; v.rlast = rlast; v.b2b = b2b;
    v.exp_cyc = cyc; v.exp_err = err;
    return v;
  endfunction

  task automatic clear_slave();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t        e;
    int unsigned c, awc, wc, arc, bc, rc;
    bit          done, aw_wait, w_wait, ar_wait;
    logic [3:0]  es;
    es = (v.strb == 4'h0) ? 4'hF : v.strb;
    if (!v.b2b) begin
      @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
    end
    @(negedge clk);
    chk({name, " pready before setup"}, bus.pready, 1'b0);
    chk({name, " pslverr before setup"}, bus.pslverr, 1'b0);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = v.wr;
    bus.paddr = v.addr; bus.pwdata = v.wdata; bus.pstrb = v.strb; bus.pprot = v.prot;
    if (!v.wr) last_rd = v.rdata;
    e.name = name; e.cyc = v.exp_cyc; e.err = v.exp_err; e.prdata = last_rd;
    sbq.push_back(e);
    done = 0; c = 0; awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    while (!done) begin
      @(negedge clk);
      c++;
      bus.penable = 1'b1;
      if (aw_wait) chk({name, " awvalid held"}, bus.awvalid, 1'b1);
      if (w_wait)  chk({name, " wvalid held"}, bus.wvalid, 1'b1);
      if (ar_wait) chk({name, " arvalid held"}, bus.arvalid, 1'b1);
      bus.awready = bus.awvalid && (awc >= v.aw_st);
      bus.wready  = bus.wvalid && (wc >= v.w_st);
      bus.arready = bus.arvalid && (arc >= v.ar_st);
      if (bus.awvalid) awc++;
      if (bus.wvalid)  wc++;
      if (bus.arvalid) arc++;
      if (bus.awvalid && bus.awready) begin
        chk({name, " awaddr"}, bus.awaddr, {v.addr[31:2], 2'b00});
        chk({name, " aw fixed"}, {bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awid},
            {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 4'hA});
        chk({name, " awprot"}, bus.awprot, v.prot);
      end
      if (bus.wvalid && bus.wready) begin
        chk({name, " wdata"}, bus.wdata, v.wdata);
        chk({name, " wstrb"}, bus.wstrb, es);
        chk({name, " wlast/wid"}, {bus.wlast, bus.wid}, {1'b1, 4'hA});
      end
      if (bus.arvalid && bus.arready) begin
        chk({name, " araddr"}, bus.araddr, {v.addr[31:2], 2'b00});
        chk({name, " ar fixed"}, {bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arid},
            {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 4'hA});
        chk({name, " arprot"}, bus.arprot, v.prot);
      end
      if (bus.bready) chk({name, " bready after both handshakes"}, {bus.awvalid, bus.wvalid}, 2'b00);
      bus.bvalid = bus.bready && (bc >= v.b_st);
      if (bus.bready) bc++;
      bus.bresp = bus.bvalid ? v.resp : 2'b00;
      bus.rvalid = bus.rready && (rc >= v.r_st);
      if (bus.rready) rc++;
      bus.rresp = bus.rvalid ? v.resp : 2'b00;
      bus.rlast = bus.rvalid ? v.rlast : 1'b0;
      bus.rdata = bus.rvalid ? v.rdata : 32'h0;
      aw_wait = bus.awvalid && !bus.awready;
      w_wait  = bus.wvalid && !bus.wready;
      ar_wait = bus.arvalid && !bus.arready;
      if (bus.pready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s: pready with no outstanding transfer expected", name);
        end else begin
          e = sbq.pop_front();
          chk({e.name, " pready cycle"}, c, e.cyc);
          chk({e.name, " pslverr"}, bus.pslverr, e.err);
          chk({e.name, " prdata"}, bus.prdata, e.prdata);
        end
        done = 1;
      end else if (c >= MAXCYC) begin
        n_cmp++; n_bad++;
        $display("FAIL %s timeout: no pready after %0d cycles, expected at %0d", name, c, v.exp_cyc);
        if (sbq.size() != 0) void'(sbq.pop_front());
        done = 1;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; last_rd = '0;
    tbl[0]  = mk(1, 32'h1000_0006, 32'hA5A5_1234, 4'b1100, 3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1, 0, 3, 0);
    tbl[1]  = mk(0, 32'h2000_0000, 32'h0,         4'hF,    3'd0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1, 0, 3, 0);
    tbl[2]  = mk(1, 32'h1000_0100, 32'h1111_2222, 4'hF,    3'd1, 3, 0, 0, 0, 0, 2'b00, 32'h0, 1, 0, 6, 0);
    tbl[3]  = mk(1, 32'h1000_0200, 32'h3333_4444, 4'b0011, 3'd2, 0, 3, 0, 0, 0, 2'b00, 32'h0, 1, 0, 6, 0);
    tbl[4]  = mk(1, 32'h1000_0300, 32'h5555_6666, 4'hF,    3'd0, 0, 0, 0, 0, 0, 2'b10, 32'h0, 1, 0, 3, 1);
    tbl[5]  = mk(0, 32'h2000_0104, 32'h0,         4'hF,    3'd0, 0, 0, 0, 0, 0, 2'b11, 32'hCAFE_0001, 1, 0, 3, 1);
    tbl[6]  = mk(0, 32'h2000_0208, 32'h0,         4'hF,    3'd0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_0002, 0, 0, 3, 1);
    tbl[7]  = mk(0, 32'h2000_030F, 32'h0,         4'hF,    3'd5, 0, 0, 1, 0, 2, 2'b00, 32'h7654_3210, 1, 0, 6, 0);
    tbl[8]  = mk(1, 32'h3000_000B, 32'h0BAD_F00D, 4'h0,    3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1, 0, 3, 0);
    tbl[9]  = mk(0, 32'h4000_0010, 32'h0,         4'hF,    3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 1, 1, 3, 0);
    tbl[10] = mk(1, 32'h5000_0020, 32'h9999_AAAA, 4'b0101, 3'd3, 2, 2, 0, 2, 0, 2'b00, 32'h0, 1, 0, 7, 0);
    tbl[11] = mk(1, 32'h5000_0024, 32'hBBBB_CCCC, 4'b1000, 3'd6, 1, 0, 0, 0, 0, 2'b01, 32'h0, 1, 1, 4, 0);

    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    bus.bid = 4'h3; bus.rid = 4'h5;
    clear_slave();
    repeat (3) @(negedge clk);
    chk("reset valids/readies", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.pready}, 6'b0);
    chk("reset pslverr/prdata", {bus.pslverr, bus.prdata}, 33'h0);
    chk("reset addr/data", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot}, 106'h0);
    rst_n = 1'b1;

    // Access phase without a preceding setup phase must not start a transfer.
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle ignores access phase", {bus.awvalid, bus.wvalid, bus.arvalid, bus.pready}, 4'b0);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;

    for (int unsigned i = 0; i < NVEC; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for the read response.
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    clear_slave();
    @(negedge clk);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h6000_0000;
    @(negedge clk);
    bus.penable = 1'b1;
    chk("rst seq arvalid", bus.arvalid, 1'b1);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    chk("rst seq rready", {bus.rready, bus.arvalid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {bus.rready, bus.arvalid, bus.pready, bus.awvalid, bus.wvalid, bus.bready}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    last_rd = '0;
    chk("post-reset prdata", {bus.prdata, bus.pslverr}, 33'h0);
    run_vec(mk(1, 32'h7000_0044, 32'hFEED_0042, 4'b0110, 3'd1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1, 0, 3, 0),
            "post-reset write");

    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard drain: %0d transfers left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb2axi_bridge_single.md
# apb2axi_bridge_single

APB-slave to AXI-master bridge: converts each APB transfer into exactly one single-beat (len 0), 32-bit AXI read or write and holds the APB access phase until the AXI response returns. It is the reverse-direction companion to the AXI-to-APB bridges in the SoC interconnect. It lets APB-side agents (debug, boot, and config masters) reach AXI memory and peripherals. Only one transaction is ever outstanding.

## Interface
- ADDR_W, 32, APB/AXI address width.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant driven on awid/wid/arid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_W  APB address.
- pwdata  in  32  write data.
- pstrb  in  4  write byte strobes.
- pprot  in  3  protection, forwarded to awprot/arprot.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  ID_W/ADDR_W/4/3/2/2/4/3  write address.
- awvalid  out  1; awready  in  1.
- wid  out  ID_W; wdata  out  32; wstrb  out  4; wlast  out  1; wvalid  out  1; wready  in  1.
- bid  in  ID_W; bresp  in  2; bvalid  in  1; bready  out  1.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  same widths as aw*; arvalid  out  1; arready  in  1.
- rid  in  ID_W; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.

## Operation
- Fixed AXI fields:
  - len = 0, size = 3'b010, burst = 2'b01 (INCR), lock = 0, cache = 0, wlast = 1.
  - id = AXI_ID.
  - prot = captured pprot.
- Address is word-aligned: awaddr/araddr = {paddr[ADDR_W-1:2], 2'b00}.
- Write strobes: wstrb = captured pstrb. pstrb == 0 is sent as 4'hF, so APB3 masters perform full-word writes.
- States: IDLE, W_REQ, W_RESP, R_REQ, R_RESP, DONE.
- IDLE:
  - Capture happens only on psel & ~penable (setup phase): paddr, pwdata, pstrb, pprot, pwrite.
  - Next state is W_REQ if pwrite = 1, otherwise R_REQ.
  - psel & penable seen in IDLE is ignored.
- W_REQ:
  - awvalid and wvalid rise together on entry.
  - Each drops independently on its own handshake; a valid is never withdrawn before its ready.
  - Go to W_RESP in the cycle after both handshakes have completed, including when both complete in the same cycle.
- W_RESP: bready = 1. On bvalid, set pslverr_n = bresp[1] and go to DONE.
- R_REQ: arvalid = 1 until arready; then go to R_RESP.
- R_RESP: rready = 1. On the first rvalid:
  - capture prdata = rdata;
  - set pslverr = rresp[1] | ~rlast;
  - go to DONE.
- DONE: pready = 1 for exactly one cycle, then IDLE.
- Result hold rules:
  - prdata is updated only by reads and holds its value across writes.
  - pslverr is valid while pready = 1 and is cleared on leaving DONE.
- bid/rid are not checked; any response is accepted as belonging to the outstanding transfer.
- psel dropping mid-transaction (APB protocol violation): the AXI transaction still completes, DONE is still pulsed, and the bridge returns to IDLE.
- Asynchronous reset mid-transaction:
  - all valid/ready outputs go low immediately and state goes to IDLE;
  - the outstanding AXI transaction is abandoned, and the system resets the AXI slave with the bridge.

## Timing
- Reset values:
  - every valid/ready output (awvalid, wvalid, arvalid, bready, rready, pready) = 0;
  - pslverr = 0, prdata = 0;
  - awaddr/araddr/wdata/wstrb/prot = 0.
- All outputs are registered or decoded from state; there is no combinational path from APB inputs to AXI outputs.
- Write, minimum-latency sequence:
  - T0: setup phase.
  - T1: W_REQ; awvalid = wvalid = 1, awready = wready = 1.
  - T2: W_RESP; bvalid = 1.
  - T3: DONE; pready = 1.
  - The APB transfer is 4 cycles, 2 wait states.
- Read, minimum-latency sequence:
  - T0: setup.
  - T1: arvalid & arready.
  - T2: rvalid.
  - T3: pready with prdata.
- Each cycle of AXI ready/valid stall adds one cycle of wait.
- A back-to-back APB setup phase is accepted in the cycle after DONE.

## Test plan
1. Write, zero AXI stall:
   - Stimulus: paddr = 0x1000_0006, pwdata = 0xA5A5_1234, pstrb = 4'b1100.
   - Required: awaddr = 0x1000_0004, wstrb = 4'b1100, awlen = 0, awsize = 2, wlast = 1; pready at T3, pslverr = 0.
2. Read, zero AXI stall:
   - Stimulus: paddr = 0x2000_0000; slave returns rdata = 0xDEAD_BEEF, rresp = 0, rlast = 1.
   - Required: prdata = 0xDEAD_BEEF with pready at T3.
3. Independent AW/W stalls:
   - Stimulus: awready held 0 for 3 cycles while wready = 1 immediately, then the reverse ordering in a second transfer.
   - Required: valids stay high until their own handshake; bready asserts only after both handshakes; pready at T6.
4. Error mapping:
   - Stimulus: bresp = 2'b10 on a write; rresp = 2'b11 on a read; rlast = 0 with rresp = 0 on a read.
   - Required: pslverr = 1 with pready in all three cases; pslverr = 0 on the following good transfer.
5. pstrb = 0 write and back-to-back transfers:
   - Stimulus: a write with pstrb = 0, immediately followed by a read.
   - Required: wstrb = 4'hF on the write; the read's setup phase is accepted the cycle after DONE.
6. Reset mid-transaction:
   - Stimulus: assert rst_n = 0 while in R_RESP with rready = 1.
   - Required: rready, arvalid, and pready drop asynchronously; after release the bridge is in IDLE and a new write completes normally.
